// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters.
// Fetch predicts direction and target from PCF. Execute checks the carried
// prediction against the resolved outcome, raises a redirect on a mismatch,
// and trains the table on the following clock edge.
module branch_predictor #(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    output logic        predictTakenF,
    output logic [31:0] predictedTargetF,
    input  logic        branchE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCTargetE,
    input  logic        branchTakenE,
    input  logic        predictedTakenE,
    input  logic [31:0] predictedTargetE,
    output logic        mispredictE,
    output logic [31:0] PCRedirectE,
    output logic [31:0] branchCount,
    output logic [31:0] mispredictCount
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = 30 - IDX;

    // Table state: valid and ctr have defined reset values, tag and target do not.
    logic [ENTRIES-1:0] valid;
    logic [1:0]         ctr    [ENTRIES];
    logic [TW-1:0]      tag    [ENTRIES];
    logic [31:0]        target [ENTRIES];

    logic [IDX-1:0] idx_f;
    logic [IDX-1:0] idx_e;
    logic [TW-1:0]  tag_f;
    logic [TW-1:0]  tag_e;
    logic           hit_f;
    logic           hit_e;

    // Instruction PCs are word aligned, so the low two bits carry no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

    assign idx_f = PCF[IDX+1:2];
    assign tag_f = PCF[31:IDX+2];
    assign idx_e = PCE[IDX+1:2];
    assign tag_e = PCE[31:IDX+2];

    assign hit_f = valid[idx_f] && (tag[idx_f] == tag_f);
    assign hit_e = valid[idx_e] && (tag[idx_e] == tag_e);

    // Fetch lookup reads registered state only, so a same-cycle write is not visible.
    always_comb begin
        predictTakenF    = hit_f & ctr[idx_f][1];
        predictedTargetF = predictTakenF ? target[idx_f] : PCF + 32'd4;
    end

    // Execute check: compare the carried prediction with the resolved outcome.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mispredictE = 1'b0;
        PCRedirectE = branchTakenE ? PCTargetE : PCE + 32'd4;
        if (branchE) begin
            mispredictE = (branchTakenE != predictedTakenE) |
                          (branchTakenE & predictedTakenE & (predictedTargetE != PCTargetE));
        end
    end

    // Valid bits and direction counters: cleared by reset, trained by resolved branches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all sequential state so every read sees pre-edge values.
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (branchE) begin
            if (hit_e) begin
                if (branchTakenE) begin
                    ctr[idx_e] <= (ctr[idx_e] == 2'b11) ? 2'b11 : ctr[idx_e] + 2'd1;
                end else begin
                    ctr[idx_e] <= (ctr[idx_e] == 2'b00) ? 2'b00 : ctr[idx_e] - 2'd1;
                end
            end else if (branchTakenE) begin
                valid[idx_e] <= 1'b1;
                ctr[idx_e]   <= 2'b10;
            end
        end
    end

    // Tag and target payload: written on taken resolutions, gated off while in reset.
    always_ff @(posedge clk) begin
        // NOTE: payload is deliberately not reset; valid guards it, so it can map to plain RAM.
        if (rst_n && branchE && branchTakenE) begin
            target[idx_e] <= PCTargetE;
            if (!hit_e) begin
                tag[idx_e] <= tag_e;
            end
        end
    end

    // Statistics counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branchCount     <= '0;
            mispredictCount <= '0;
        end else if (branchE) begin
            branchCount <= branchCount + 32'd1;
            if (mispredictE) begin
                mispredictCount <= mispredictCount + 32'd1;
            end
        end
    end

endmodule
